// File: rtl/wishbone_stream_fifo.sv
// ---------------------------------------------------------------------------
// wishbone_stream_fifo
//
// Wishbone classic device that pushes bus writes into a synchronous FIFO and
// drains the FIFO through a valid/ready stream port. Bus reads return the
// current FIFO occupancy so a controller can poll for free space.
//
// Handshakes:
//   Wishbone: a request (cyc_i & stb_i) is decided only in IDLE. The response
//   (ack_o, or rty_o when enabled) is registered and lasts exactly one cycle
//   in RESP, after which the FSM always returns to IDLE. A request still high
//   in RESP is treated as a new cycle once back in IDLE.
//   Stream: a beat transfers on every rising edge where m_valid_o and
//   m_ready_i are both high. m_valid_o may not depend on m_ready_i.
//
// Optional feature (macro WB_FIFO_RTY_EN):
//   defined   - a write to a full FIFO is answered with a one-cycle rty_o
//               and nothing is pushed.
//   undefined - a write to a full FIFO is held with wait states until space
//               frees up; rty_o is tied 0.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   cyc_i, stb_i, we_i  Wishbone cycle, strobe, write enable
//   dat_i               write data (pushed into FIFO)
//   ack_o, err_o, rty_o registered acknowledge, error (tied 0), retry
//   dat_o               read data (occupancy) while ack_o, else 0
//   m_valid_o, m_data_o stream output (FIFO head), m_ready_i consumer ready
// ---------------------------------------------------------------------------
module wishbone_stream_fifo #(
  parameter int DAT_WIDTH = 8,
  parameter int DEPTH     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  input  logic                 we_i,
  input  logic [DAT_WIDTH-1:0] dat_i,
  output logic                 ack_o,
  output logic                 err_o,
  output logic                 rty_o,
  output logic [DAT_WIDTH-1:0] dat_o,
  output logic                 m_valid_o,
  output logic [DAT_WIDTH-1:0] m_data_o,
  input  logic                 m_ready_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("wishbone_stream_fifo: DEPTH must be a power of two and >= 2");
    end
    if (CNT_W > DAT_WIDTH) begin : g_bad_width
      $error("wishbone_stream_fifo: occupancy does not fit in DAT_WIDTH");
    end
  endgenerate

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic                 ack_q, ack_d;
  logic                 rty_q, rty_d;
  logic [DAT_WIDTH-1:0] dat_q, dat_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DAT_WIDTH-1:0] mem_q [DEPTH];

  logic request;
  logic full;
  logic empty;
  logic push;
  logic pop;

  assign request = cyc_i & stb_i;
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = ~empty & m_ready_i;

  // Bus FSM: decisions happen only in IDLE; RESP is a single response cycle.
  // Full is judged on the registered count, i.e. before this edge's pop.
  always_comb begin
    state_d = ST_IDLE;
    ack_d   = 1'b0;
    rty_d   = 1'b0;
    dat_d   = '0;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (request) begin
          if (!we_i) begin
            state_d = ST_RESP;
            ack_d   = 1'b1;
            dat_d   = DAT_WIDTH'(count_q);
          end else if (!full) begin
            state_d = ST_RESP;
            ack_d   = 1'b1;
            push    = 1'b1;
          end else begin
`ifdef WB_FIFO_RTY_EN
            state_d = ST_RESP;
            rty_d   = 1'b1;
`else
            // Wait states: stay in IDLE and re-decide next edge.
            state_d = ST_IDLE;
`endif
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO bookkeeping; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      ack_q    <= 1'b0;
      rty_q    <= 1'b0;
      dat_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      rty_q    <= rty_d;
      dat_q    <= dat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until count_q says so.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= dat_i;
  end

  assign ack_o     = ack_q;
  assign rty_o     = rty_q;
  assign err_o     = 1'b0;
  assign dat_o     = dat_q;
  assign m_valid_o = ~empty;
  assign m_data_o  = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_wishbone_stream_fifo.sv
// ---------------------------------------------------------------------------
// Bench for wishbone_stream_fifo (DAT_WIDTH=8, DEPTH=16).
// Stimulus pushes expected bus responses and stream beats into queues; two
// monitors on the falling edge pop and compare whenever the DUT responds.
// ---------------------------------------------------------------------------
module tb_wishbone_stream_fifo;
  localparam int W     = 8;
  localparam int DEPTH = 16;

  // Clock / reset
  logic         clk = 1'b0;
  logic         rst_i;
  logic         cyc_i, stb_i, we_i;
  logic [W-1:0] dat_i;
  logic         ack_o, err_o, rty_o;
  logic [W-1:0] dat_o;
  logic         m_valid_o;
  logic [W-1:0] m_data_o;
  logic         m_ready_i;

  always #5 clk = ~clk;

  wishbone_stream_fifo #(.DAT_WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .cyc_i     (cyc_i),
    .stb_i     (stb_i),
    .we_i      (we_i),
    .dat_i     (dat_i),
    .ack_o     (ack_o),
    .err_o     (err_o),
    .rty_o     (rty_o),
    .dat_o     (dat_o),
    .m_valid_o (m_valid_o),
    .m_data_o  (m_data_o),
    .m_ready_i (m_ready_i)
  );

  // Scoreboard state
  int           n_cmp = 0;
  int           n_err = 0;
  logic [W+2:0] bus_q[$];  // {check_data, rty, ack, data}
  logic [W-1:0] exp_q[$];  // expected stream beats in order

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W+2:0] mk(input logic chk, input logic rty, input logic ack,
                                      input logic [W-1:0] d);
    return {chk, rty, ack, d};
  endfunction

  // Bus response monitor
  always @(negedge clk) begin
    logic [W+2:0] e;
    if (rst_i === 1'b0 && (ack_o === 1'b1 || rty_o === 1'b1)) begin
      if (bus_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_bus_resp: ack=%0b rty=%0b, expected none", ack_o, rty_o);
      end else begin
        e = bus_q.pop_front();
        check("bus_ack", ack_o, e[W]);
        check("bus_rty", rty_o, e[W+1]);
        check("bus_err", err_o, 0);
        if (e[W+2]) check("bus_dat", dat_o, e[W-1:0]);
      end
    end
  end

  // Stream monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_i === 1'b0 && m_valid_o === 1'b1 && m_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got 0x%0h, expected none", m_data_o);
      end else begin
        e = exp_q.pop_front();
        check("stream_data", m_data_o, e);
      end
    end
  end

  // Driver tasks: each starts one edge later so the FSM is back in IDLE.
  task automatic wb_xfer(input logic we, input logic [W-1:0] d, input int exp_wait,
                         input string name);
    int waits;
    waits = 0;
    @(posedge clk); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; dat_i = d;
    do begin
      @(posedge clk); #1;
      waits++;
    end while (!(ack_o || rty_o) && waits < 100);
    check(name, waits, exp_wait);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; dat_i = '0;
  endtask

  task automatic wb_write(input logic [W-1:0] d);
    bus_q.push_back(mk(1'b0, 1'b0, 1'b1, '0));
    exp_q.push_back(d);
    wb_xfer(1'b1, d, 1, "write_latency");
  endtask

  task automatic wb_read(input logic [W-1:0] exp_cnt);
    bus_q.push_back(mk(1'b1, 1'b0, 1'b1, exp_cnt));
    wb_xfer(1'b0, '0, 1, "read_latency");
  endtask

  // Request held high across acks: first ack after 1 edge, then every 2.
  task automatic wb_burst(input int n, input logic [W-1:0] base);
    int waits;
    for (int i = 0; i < n; i++) begin
      bus_q.push_back(mk(1'b0, 1'b0, 1'b1, '0));
      exp_q.push_back(base + W'(i));
    end
    @(posedge clk); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      dat_i = base + W'(i);
      waits = 0;
      do begin
        @(posedge clk); #1;
        waits++;
      end while (!ack_o && waits < 100);
      check("burst_ack_spacing", waits, (i == 0) ? 1 : 2);
    end
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; dat_i = '0;
  endtask

  task automatic wait_drain(input int exp_n, input string name);
    int n;
    n = 0;
    while (m_valid_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, n, exp_n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; dat_i = '0; m_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    // Reset state
    repeat (10) @(posedge clk);
    #1;
    check("rst_ack", ack_o, 0);
    check("rst_rty", rty_o, 0);
    check("rst_err", err_o, 0);
    check("rst_valid", m_valid_o, 0);
    check("rst_dat", dat_o, 0);
    wb_read(8'd0);

    // Single write
    wb_write(8'hA5);
    check("single_valid", m_valid_o, 1);
    check("single_data", m_data_o, 8'hA5);
    wb_read(8'd1);
    m_ready_i = 1'b1;
    wait_drain(1, "single_drain");
    m_ready_i = 1'b0;

    // Fill and drain
    for (int i = 0; i < DEPTH; i++) wb_write(W'(i));
    wb_read(8'd16);
    m_ready_i = 1'b1;
    wait_drain(16, "fill_drain_len");
    check("fill_drain_empty", m_valid_o, 0);
    m_ready_i = 1'b0;

    // Write while full
    for (int i = 0; i < DEPTH; i++) wb_write(8'h10 + W'(i));
`ifdef WB_FIFO_RTY_EN
    bus_q.push_back(mk(1'b0, 1'b1, 1'b0, '0));
    wb_xfer(1'b1, 8'h55, 1, "full_rty_latency");
    wb_read(8'd16);
    m_ready_i = 1'b1;
    wait_drain(16, "full_rty_drain");
`else
    fork
      begin
        bus_q.push_back(mk(1'b0, 1'b0, 1'b1, '0));
        exp_q.push_back(8'h55);
        wb_xfer(1'b1, 8'h55, 6, "full_stall_latency");
      end
      begin
        repeat (5) @(posedge clk);
        #1 m_ready_i = 1'b1;
      end
    join
    wait_drain(15, "full_stall_drain");
`endif
    check("full_stream_consumed", exp_q.size(), 0);
    m_ready_i = 1'b0;

    // Wrap-around with concurrent push/pop
    m_ready_i = 1'b1;
    wb_burst(40, 8'h80);
    wb_read(8'd0);
    check("wrap_empty", m_valid_o, 0);
    m_ready_i = 1'b0;

    // Reset mid-operation with a write pending
    for (int i = 0; i < 5; i++) wb_write(8'hC0 + W'(i));
    @(posedge clk); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; dat_i = 8'hEE;
    rst_i = 1'b1;
    @(posedge clk); #1;
    check("midrst_ack", ack_o, 0);
    check("midrst_valid", m_valid_o, 0);
    rst_i = 1'b0;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; dat_i = '0;
    exp_q.delete();
    wb_read(8'd0);

    repeat (3) @(posedge clk);
    #1;
    check("bus_q_drained", bus_q.size(), 0);
    check("stream_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
